// File: rtl/alu_pkg.sv
// Shared types and sizes for the 16-bit execute/writeback stage.
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int NREG   = 16;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} alu_op_e;
endpackage

// File: rtl/div16_restoring.sv
// Combinational 16-stage unsigned restoring divider; divide by zero yields q=all ones, r=dividend.
module div16_restoring
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] r
);

  logic [DATA_W:0] part;

  always_comb begin
    part = '0;
    q    = '0;
    r    = '0;
    // part stays below the divisor after each stage, so 17 bits hold the shifted value
    for (int i = DATA_W - 1; i >= 0; i--) begin
      part = {part[DATA_W-1:0], dividend[i]};
      if (part >= {1'b0, divisor}) begin
        part = part - {1'b0, divisor};
        q[i] = 1'b1;
      end
    end
    r = part[DATA_W-1:0];
    if (divisor == '0) begin
      q = '1;
      r = dividend;
    end
  end

endmodule

// File: rtl/alu_wb_unit.sv
// Single-cycle add/sub/mul/div execute stage writing into a 16-entry register file with per-op flags.
module alu_wb_unit
  import alu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [1:0]               f0,
  input  logic [3:0]               opcode_rd,
  input  logic [DATA_W-1:0]        rs1,
  input  logic [DATA_W-1:0]        rs2,
  input  logic                     cin,
  input  logic                     bin,
  output logic [NREG*DATA_W-1:0]   out_wb,
  output logic                     cout,
  output logic                     borrow,
  output logic                     ovf,
  output logic                     div_zero,
  output logic [DATA_W-1:0]        rem
);

  logic [DATA_W-1:0]   regs [NREG];
  logic [DATA_W:0]     add_full;
  logic [DATA_W:0]     sub_full;
  logic [2*DATA_W-1:0] mul_full;
  logic [DATA_W-1:0]   div_q;
  logic [DATA_W-1:0]   div_r;
  logic [DATA_W-1:0]   result;
  alu_op_e             op;

  assign op       = alu_op_e'(f0);
  assign add_full = {1'b0, rs1} + {1'b0, rs2} + {{DATA_W{1'b0}}, cin};
  // a negative 17-bit difference sets the top bit, which is exactly rs1 < rs2 + bin
  assign sub_full = {1'b0, rs1} - {1'b0, rs2} - {{DATA_W{1'b0}}, bin};
  assign mul_full = rs1 * rs2;

  div16_restoring u_div (
    .dividend (rs1),
    .divisor  (rs2),
    .q        (div_q),
    .r        (div_r)
  );

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD: result = add_full[DATA_W-1:0];
      OP_SUB: result = sub_full[DATA_W-1:0];
      OP_MUL: result = mul_full[DATA_W-1:0];
      OP_DIV: result = div_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
      cout     <= 1'b0;
      borrow   <= 1'b0;
      ovf      <= 1'b0;
      div_zero <= 1'b0;
      rem      <= '0;
    end else if (valid_in) begin
      regs[opcode_rd] <= result;
      unique case (op)
        OP_ADD: cout   <= add_full[DATA_W];
        OP_SUB: borrow <= sub_full[DATA_W];
        OP_MUL: ovf    <= |mul_full[2*DATA_W-1:DATA_W];
        OP_DIV: begin
          div_zero <= (rs2 == '0);
          rem      <= div_r;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign out_wb[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_alu_wb_unit.sv
// Directed and random checks of alu_wb_unit against an arithmetic reference model.
module tb_alu_wb_unit;
  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [1:0]   f0;
  logic [3:0]   opcode_rd;
  logic [15:0]  rs1, rs2;
  logic         cin, bin;
  logic [255:0] out_wb;
  logic         cout, borrow, ovf, div_zero;
  logic [15:0]  rem;

  int n_checks = 0;
  int n_fail   = 0;

  longint m_reg [16];
  longint m_cout, m_borrow, m_ovf, m_dz, m_rem;

  alu_wb_unit dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .f0        (f0),
    .opcode_rd (opcode_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .cin       (cin),
    .bin       (bin),
    .out_wb    (out_wb),
    .cout      (cout),
    .borrow    (borrow),
    .ovf       (ovf),
    .div_zero  (div_zero),
    .rem       (rem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k*16 +: 16] = m_reg[k][15:0];
    return v;
  endfunction

  task automatic model_update(input logic r, input logic v, input int op, input int rd,
                              input longint a, input longint b, input longint c, input longint bi);
    longint res;
    if (r) begin
      for (int k = 0; k < 16; k++) m_reg[k] = 0;
      m_cout = 0; m_borrow = 0; m_ovf = 0; m_dz = 0; m_rem = 0;
      return;
    end
    if (!v) return;
    res = 0;
    case (op)
      0: begin res = (a + b + c) % 65536; m_cout = (a + b + c) / 65536; end
      1: begin res = (a - b - bi + 131072) % 65536; m_borrow = (a < b + bi) ? 1 : 0; end
      2: begin res = (a * b) % 65536; m_ovf = ((a * b) >= 65536) ? 1 : 0; end
      default: begin
        if (b == 0) begin res = 65535; m_rem = a; m_dz = 1; end
        else begin res = a / b; m_rem = a % b; m_dz = 0; end
      end
    endcase
    m_reg[rd] = res;
  endtask

  task automatic step(input string tag, input logic r, input logic v, input int op, input int rd,
                      input int a, input int b, input int c, input int bi);
    @(negedge clk);
    rst = r; valid_in = v; f0 = op[1:0]; opcode_rd = rd[3:0];
    rs1 = a[15:0]; rs2 = b[15:0]; cin = c[0]; bin = bi[0];
    @(posedge clk);
    model_update(r, v, op, rd, longint'(a[15:0]), longint'(b[15:0]), longint'(c[0]), longint'(bi[0]));
    #1;
    check({tag, ".regs"},     out_wb,            model_flat());
    check({tag, ".cout"},     256'(cout),        256'(m_cout));
    check({tag, ".borrow"},   256'(borrow),      256'(m_borrow));
    check({tag, ".ovf"},      256'(ovf),         256'(m_ovf));
    check({tag, ".div_zero"}, 256'(div_zero),    256'(m_dz));
    check({tag, ".rem"},      256'(rem),         256'(m_rem));
  endtask

  initial begin
    for (int k = 0; k < 16; k++) m_reg[k] = 0;
    m_cout = 0; m_borrow = 0; m_ovf = 0; m_dz = 0; m_rem = 0;
    rst = 1'b1; valid_in = 1'b0; f0 = '0; opcode_rd = '0; rs1 = '0; rs2 = '0; cin = 1'b0; bin = 1'b0;

    // reset with garbage and a valid op present
    step("rst_garbage", 1, 1, 2, 9, 16'hBEEF, 16'h1234, 1, 1);
    check("rst_reg9_zero", 256'(out_wb[9*16 +: 16]), 256'(0));
    step("rst_release_write", 0, 1, 0, 9, 2, 3, 0, 0);
    check("rst_release_reg9", 256'(out_wb[9*16 +: 16]), 256'(5));

    step("add_carry", 0, 1, 0, 3, 16'hFFFF, 1, 1, 0);
    check("add_carry_reg3", 256'(out_wb[3*16 +: 16]), 256'(16'h0001));
    check("add_carry_cout", 256'(cout), 256'(1));
    step("add_plain", 0, 1, 0, 4, 5, 7, 0, 0);
    check("add_plain_reg4", 256'(out_wb[4*16 +: 16]), 256'(12));

    step("sub_nob", 0, 1, 1, 0, 10, 3, 0, 1);
    check("sub_nob_reg0", 256'(out_wb[15:0]), 256'(6));
    step("sub_borrow", 0, 1, 1, 0, 3, 10, 0, 0);
    check("sub_borrow_reg0", 256'(out_wb[15:0]), 256'(16'hFFF9));
    check("sub_borrow_flag", 256'(borrow), 256'(1));
    step("sub_edge", 0, 1, 1, 1, 16'hFFFF, 16'hFFFF, 0, 1);

    step("mul_ovf", 0, 1, 2, 15, 300, 300, 0, 0);
    check("mul_ovf_reg15", 256'(out_wb[15*16 +: 16]), 256'(16'h5F90));
    step("mul_noovf", 0, 1, 2, 15, 255, 257, 0, 0);
    check("mul_noovf_reg15", 256'(out_wb[15*16 +: 16]), 256'(16'hFFFF));

    step("div_basic", 0, 1, 3, 7, 1000, 7, 0, 0);
    check("div_basic_rem", 256'(rem), 256'(6));
    step("div_zero", 0, 1, 3, 7, 1234, 0, 0, 0);
    check("div_zero_reg7", 256'(out_wb[7*16 +: 16]), 256'(16'hFFFF));
    step("div_by1", 0, 1, 3, 7, 65535, 1, 0, 0);
    step("idle_hold", 0, 0, 3, 7, 5, 0, 1, 1);

    for (int k = 0; k < 16; k++) begin
      step($sformatf("sweep%0d", k), 0, 1, 0, k, k + 16'hA000, 0, 0, 0);
      if (k == 5) step("sweep_idle", 0, 0, 0, 5, 0, 0, 0, 0);
    end
    for (int k = 0; k < 16; k++)
      check($sformatf("sweep_reg%0d", k), 256'(out_wb[k*16 +: 16]), 256'(k + 16'hA000));

    step("b2b_a", 0, 1, 0, 2, 1, 1, 0, 0);
    step("b2b_b", 0, 1, 0, 2, 40, 2, 0, 0);
    check("b2b_last_wins", 256'(out_wb[2*16 +: 16]), 256'(42));

    for (int n = 0; n < 300; n++) begin
      int op, rd, a, b;
      op = int'($urandom_range(3));
      rd = int'($urandom_range(15));
      a  = int'($urandom_range(65535));
      b  = (($urandom & 7) == 0) ? 0 : int'($urandom_range(65535));
      if (($urandom & 3) == 0) b = int'($urandom_range(300));
      // feed back a register as operand to exercise read-before-write
      if (($urandom & 3) == 0) a = int'(m_reg[$urandom_range(15)]);
      step($sformatf("rand%0d", n), ($urandom_range(40) == 0), ($urandom_range(4) != 0),
           op, rd, a, b, int'($urandom_range(1)), int'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
